mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates one single-port synchronous memory (1-cycle read latency) among three requesters: debug/program loader, core data access, and core instruction fetch. Priority is fixed (debug > data > fetch), with a starvation guard that forces a fetch grant after a run of consecutive data grants. The block returns read data and a completion strobe to the winning port one cycle after the grant. It sits between the RV32I core's fetch and load/store paths and a unified instruction/data RAM.

## Interface
- DEPTH, 1024: memory depth in 32-bit words; power of two.
- MAX_DRUN, 4: maximum consecutive data grants while fetch is pending, 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- dbg_req, dbg_we  in  1 each  debug request and write enable.
- dbg_addr, dbg_wdata  in  32 each  byte address and write data.
- d_req, d_we  in  1 each  core data request and write enable.
- d_addr, d_wdata  in  32 each  byte address and write data.
- i_req  in  1  fetch request (read only).
- i_addr  in  32  fetch byte address.
- dbg_gnt, d_gnt, i_gnt  out  1 each  grant, combinational, at most one high.
- dbg_rvalid, d_rvalid, i_rvalid  out  1 each  completion strobe, registered.
- rdata  out  32  read data, shared; valid only with a rvalid.
- err  out  1  registered; qualifies the current rvalid.
- mem_en, mem_we  out  1 each  memory enable and write enable.
- mem_addr  out  $clog2(DEPTH)  word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0.
- stall  out  1  combinational; high when d_req or i_req is high without its grant.

## Operation
- Winner selection each cycle:
  - If dbg_req: debug wins.
  - Else if d_req and not (i_req and drun == MAX_DRUN): data wins.
  - Else if i_req: fetch wins.
- The winner's gnt is high, and its request drives the memory port.
- A request is held until its grant is seen. The requester may change the request the cycle after its grant.
- Address check on the winner:
  - addr[1:0] != 0, or addr >= 4*DEPTH, is a bad access.
  - A bad access still gets a grant but mem_en is 0.
  - Its response has err=1 and rdata=0.
- A good access drives mem_en=1, mem_we=winner's we (0 for fetch), mem_addr=addr[$clog2(DEPTH)+1:2], and mem_wdata=winner's wdata.
- Response register: records the owner, bad flag and we of each grant. Next cycle it asserts that owner's rvalid and sets err.
  - rdata = mem_rdata for a good read.
  - rdata = 0 for writes and bad accesses.
- Writes also produce rvalid as an acknowledge.
- drun, a 4-bit counter:
  - Increments on a data grant while i_req is high, saturating at MAX_DRUN.
  - Clears on any fetch grant, or on any cycle where i_req is low.
  - Holds on debug grants.
- With no request, all gnt and mem_en are 0, and no rvalid follows.

## Timing
- Reset values:
  - All gnt, rvalid, err, mem_en and mem_we are 0.
  - rdata, mem_addr and mem_wdata are 0.
  - drun = 0; the response register holds no owner.
- Grant latency is 0 cycles, combinational from req. Response latency is exactly 1 cycle after the grant.
- Back-to-back grants are allowed every cycle. This gives full throughput of one access per cycle.
- When requests arrive together, exactly one is granted; the others see gnt=0 and must hold.
- Asserting n_rst mid-operation drops any pending response. No rvalid is produced in the first cycle after reset release.
- A debug write followed by a fetch of the same address on the next cycle returns the new data, because the memory is write-then-read ordered.
- stall must fall in the same cycle the core's pending request is granted.

## Test plan
- Reset: hold n_rst=0 with all reqs high -> all gnt=0, rvalid=0, mem_en=0. First cycle after release: dbg_gnt=1, no rvalid.
- Debug load then fetch: dbg write 0x00000004 <- 0xDEADBEEF, then i_req at 0x4 -> i_gnt the next cycle, with i_rvalid=1 and rdata=0xDEADBEEF one cycle later, err=0.
- Priority: dbg_req, d_req and i_req all high for 1 cycle -> dbg_gnt only. d_req and i_req high -> d_gnt; stall=1.
- Starvation guard, MAX_DRUN=4: d_req and i_req held continuously -> grant pattern D,D,D,D,I repeating. i_gnt in cycle 5; drun returns to 0.
- Bad address: d_req read at 0x00000002, then at 4*DEPTH -> d_gnt=1 and mem_en=0 each time; next cycle d_rvalid=1, err=1, rdata=0.
- Reset mid-access: grant i_req read, assert n_rst in the next cycle -> i_rvalid stays 0 and drun=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter (debug > data > fetch) for a 1-cycle-latency RAM,
// with a fetch starvation guard and a registered per-port response.
module mem_port_arbiter #(
  parameter int DEPTH    = 1024,
  parameter int MAX_DRUN = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     dbg_req,
  input  logic                     dbg_we,
  input  logic [31:0]              dbg_addr,
  input  logic [31:0]              dbg_wdata,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [31:0]              d_addr,
  input  logic [31:0]              d_wdata,
  input  logic                     i_req,
  input  logic [31:0]              i_addr,
  output logic                     dbg_gnt,
  output logic                     d_gnt,
  output logic                     i_gnt,
  output logic                     dbg_rvalid,
  output logic                     d_rvalid,
  output logic                     i_rvalid,
  output logic [31:0]              rdata,
  output logic                     err,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  output logic                     stall
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] MAXR = 4'(MAX_DRUN);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DBG,
    OWN_D,
    OWN_I
  } own_t;

  own_t        win;
  own_t        own_q;
  logic [3:0]  drun_q;
  logic [3:0]  drun_d;
  logic        err_q;
  logic        rd_q;
  logic        bad;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;

  // Grants are forced low while reset is held.
  always_comb begin
    win = OWN_NONE;
    if (!n_rst)
      win = OWN_NONE;
    else if (dbg_req)
      win = OWN_DBG;
    else if (d_req && !(i_req && drun_q == MAXR))
      win = OWN_D;
    else if (i_req)
      win = OWN_I;
  end

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    unique case (win)
      OWN_DBG: begin
        w_we    = dbg_we;
        w_addr  = dbg_addr;
        w_wdata = dbg_wdata;
      end
      OWN_D: begin
        w_we    = d_we;
        w_addr  = d_addr;
        w_wdata = d_wdata;
      end
      OWN_I: w_addr = i_addr;
      default: ;
    endcase
  end

  // DEPTH is a power of two, so any upper address bit marks out-of-range.
  assign bad = (win != OWN_NONE) &&
               ((w_addr[1:0] != 2'b00) || (|w_addr[31:AW+2]));

  assign dbg_gnt   = (win == OWN_DBG);
  assign d_gnt     = (win == OWN_D);
  assign i_gnt     = (win == OWN_I);
  assign stall     = (d_req && !d_gnt) || (i_req && !i_gnt);
  assign mem_en    = (win != OWN_NONE) && !bad;
  assign mem_we    = mem_en && w_we;
  assign mem_addr  = mem_en ? w_addr[AW+1:2] : '0;
  assign mem_wdata = mem_en ? w_wdata : '0;

  always_comb begin
    drun_d = drun_q;
    if (!i_req || win == OWN_I)
      drun_d = '0;
    else if (win == OWN_D && drun_q != MAXR)
      drun_d = drun_q + 4'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      own_q  <= OWN_NONE;
      drun_q <= '0;
      err_q  <= 1'b0;
      rd_q   <= 1'b0;
    end else begin
      own_q  <= win;
      drun_q <= drun_d;
      err_q  <= bad;
      rd_q   <= mem_en && !w_we;
    end
  end

  assign dbg_rvalid = (own_q == OWN_DBG);
  assign d_rvalid   = (own_q == OWN_D);
  assign i_rvalid   = (own_q == OWN_I);
  assign err        = err_q;
  assign rdata      = rd_q ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a cycle-level
// behavioural model of priority, starvation guard and memory contents.
module tb_mem_port_arbiter;

  localparam int DEPTH = 64;
  localparam int MAXD  = 4;
  localparam int AW    = 6;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        dbg_req, dbg_we, d_req, d_we, i_req;
  logic [31:0] dbg_addr, dbg_wdata, d_addr, d_wdata, i_addr;
  logic        dbg_gnt, d_gnt, i_gnt;
  logic        dbg_rvalid, d_rvalid, i_rvalid;
  logic [31:0] rdata;
  logic        err, mem_en, mem_we, stall;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DEPTH(DEPTH), .MAX_DRUN(MAXD)) dut (
    .clk(clk), .n_rst(n_rst),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_req(i_req), .i_addr(i_addr),
    .dbg_gnt(dbg_gnt), .d_gnt(d_gnt), .i_gnt(i_gnt),
    .dbg_rvalid(dbg_rvalid), .d_rvalid(d_rvalid), .i_rvalid(i_rvalid),
    .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  // Synchronous RAM the arbiter drives.
  logic [31:0] ram [DEPTH];
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end

  int          nvec = 0;
  int          nbad = 0;
  logic [31:0] ref_mem [DEPTH];
  int          drun = 0;
  int          exp_own = 0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_rd = '0;
  int          last_win = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_bad(logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
  endfunction

  function automatic logic [2:0] onehot(int w);
    return (w == 1) ? 3'b100 : (w == 2) ? 3'b010 :
           (w == 3) ? 3'b001 : 3'b000;
  endfunction

  // Inputs are set just after a rising edge; checks run on the falling edge.
  task automatic cyc();
    int          win;
    logic [31:0] a, wd;
    logic        we, bd;
    logic [AW-1:0] wi;
    @(negedge clk);
    win = 0;
    if (n_rst) begin
      if (dbg_req) win = 1;
      else if (d_req && !(i_req && drun >= MAXD)) win = 2;
      else if (i_req) win = 3;
    end
    a = '0; wd = '0; we = 1'b0;
    if (win == 1) begin a = dbg_addr; wd = dbg_wdata; we = dbg_we; end
    if (win == 2) begin a = d_addr; wd = d_wdata; we = d_we; end
    if (win == 3) a = i_addr;
    bd = (win != 0) && is_bad(a);
    wi = a[AW+1:2];
    if (!n_rst) begin
      exp_own = 0; exp_err = 1'b0; exp_rd = '0; drun = 0;
    end
    check("gnt", {29'd0, dbg_gnt, d_gnt, i_gnt}, {29'd0, onehot(win)});
    check("stall", {31'd0, stall},
          {31'd0, (d_req && win != 2) || (i_req && win != 3)});
    check("mem_en", {31'd0, mem_en}, {31'd0, win != 0 && !bd});
    check("mem_we", {31'd0, mem_we}, {31'd0, win != 0 && !bd && we});
    if (win != 0 && !bd) begin
      check("mem_addr", {26'd0, mem_addr}, {26'd0, wi});
      check("mem_wdata", mem_wdata, wd);
    end
    check("rvalid", {29'd0, dbg_rvalid, d_rvalid, i_rvalid},
          {29'd0, onehot(exp_own)});
    check("err", {31'd0, err}, {31'd0, exp_err});
    check("rdata", rdata, exp_rd);
    if (n_rst) begin
      exp_own = win;
      exp_err = bd;
      exp_rd  = (win == 0 || bd || we) ? 32'd0 : ref_mem[wi];
      if (win != 0 && !bd && we) ref_mem[wi] = wd;
      if (!i_req || win == 3) drun = 0;
      else if (win == 2 && drun < MAXD) drun++;
    end
    last_win = win;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'(4 * DEPTH) + ($urandom_range(0, 3) << 2);
    if (r == 1) return ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
    return $urandom_range(0, 15) << 2;
  endfunction

  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      ram[k] = '0;
      ref_mem[k] = '0;
    end
    mem_rdata = '0;
    n_rst = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1;
    dbg_addr = 32'h4; dbg_wdata = 32'hDEADBEEF;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8; d_wdata = 32'h0;
    i_req = 1'b1; i_addr = 32'hC;
    #2;
    repeat (3) cyc();
    n_rst = 1'b1;
    cyc();
    // Debug load then fetch of the same word.
    dbg_req = 1'b0; d_req = 1'b0;
    i_req = 1'b1; i_addr = 32'h4;
    cyc();
    i_req = 1'b0;
    cyc();
    // All three, then data against fetch with starvation guard.
    dbg_req = 1'b1; dbg_we = 1'b0; d_req = 1'b1; i_req = 1'b1;
    cyc();
    dbg_req = 1'b0;
    repeat (12) cyc();
    // Bad addresses.
    i_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h2;
    cyc();
    d_addr = 32'(4 * DEPTH);
    cyc();
    d_req = 1'b0;
    cyc();
    // Reset while a fetch response is pending.
    i_req = 1'b1; i_addr = 32'h8;
    cyc();
    i_req = 1'b0; n_rst = 1'b0;
    cyc();
    n_rst = 1'b1;
    cyc();
    // Random traffic; ungranted requests are held unchanged.
    for (int n = 0; n < 3000; n++) begin
      if (!(dbg_req && last_win != 1)) begin
        dbg_req = ($urandom_range(0, 99) < 12);
        dbg_we = $urandom_range(0, 1) == 1;
        dbg_addr = rnd_addr(); dbg_wdata = $urandom;
      end
      if (!(d_req && last_win != 2)) begin
        d_req = ($urandom_range(0, 99) < 70);
        d_we = $urandom_range(0, 1) == 1;
        d_addr = rnd_addr(); d_wdata = $urandom;
      end
      if (!(i_req && last_win != 3)) begin
        i_req = ($urandom_range(0, 99) < 75);
        i_addr = rnd_addr();
      end
      if ($urandom_range(0, 499) == 0) n_rst = 1'b0;
      else n_rst = 1'b1;
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
